// File: rtl/boot_mem.sv
// boot_mem: boot memory on the s80x86 data bus, optionally writable as shadow RAM.
//
// Accepts a chip-select qualified request, inserts wait_states extra cycles, returns read data
// with a one-cycle ack, then spends one turnaround cycle ignoring requests.
//
// Build option: define BOOT_MEM_WRITE_EN to compile in the shadow-RAM write path and the sticky
// write-protect lock. Without it the block is a ROM: writes are acked but dropped, locked
// reads 1 and wp_violation reads 0.
//
// Parameters:
//   depth        number of 16-bit words (power of two, >= 2)
//   wait_states  extra cycles between acceptance and ack (0..15)
//   init_file    memory image loaded by the FPGA tools
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   cs                 address decode hit for this block
//   data_m_access      bus request, held by the master until ack
//   data_m_ack         one-cycle completion pulse
//   data_m_addr        word address [19:1]; bits above $clog2(depth) are ignored (aliasing)
//   data_m_data_in     write data
//   data_m_data_out    read data, 0 whenever data_m_ack is 0
//   data_m_bytesel     byte lane enables (bit 0 = [7:0], bit 1 = [15:8])
//   data_m_wr_en       1 = write, 0 = read
//   lock               one-cycle pulse setting the write-protect lock
//   locked             current lock state
//   wp_violation       sticky: a write was dropped while locked
module boot_mem #(
   parameter int unsigned depth       = 32,
   parameter int unsigned wait_states = 0,
   parameter string       init_file   = "bios.mif"
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        data_m_access,
   output logic        data_m_ack,
   input  logic [19:1] data_m_addr,
   input  logic [15:0] data_m_data_in,
   output logic [15:0] data_m_data_out,
   input  logic [1:0]  data_m_bytesel,
   input  logic        data_m_wr_en,
   input  logic        lock,
   output logic        locked,
   output logic        wp_violation
);

   localparam int unsigned AddrW = $clog2(depth);
   localparam int unsigned CntW  = 4;

   // Elaboration-time parameter sanity checks.
   if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
      $error("boot_mem: depth must be a power of two and at least 2");
   end
   if (wait_states > 15) begin : g_bad_wait
      $error("boot_mem: wait_states must be in 0..15");
   end
   if (init_file == "") begin : g_bad_init
      $error("boot_mem: init_file must name a memory image");
   end

   typedef enum logic [1:0] {StIdle, StWait, StAck, StTurn} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [AddrW-1:0]    addr_q, addr_d;
   logic [1:0]          bsel_q, bsel_d;
   logic                wr_q, wr_d;
   logic [15:0]         rdata_q;
   logic [15:0]         lane_mask;
   logic                accept;
   logic                unused_addr;

   assign accept      = (state_q == StIdle) && cs && data_m_access;
   assign lane_mask   = {{8{bsel_q[1]}}, {8{bsel_q[0]}}};
   // Bits above the decoded window only alias; fold them away.
   assign unused_addr = ^data_m_addr;

   // Request capture. addr_d is also the memory read address, so the synchronous read of the
   // captured word is already valid in the first cycle after acceptance.
   always_comb begin
      addr_d = addr_q;
      bsel_d = bsel_q;
      wr_d   = wr_q;
      if (accept) begin
         addr_d = data_m_addr[AddrW:1];
         bsel_d = data_m_bytesel;
         wr_d   = data_m_wr_en;
      end
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (wait_states > 0) begin
                  state_d = StWait;
                  cnt_d   = CntW'(wait_states - 1);
               end else begin
                  state_d = StAck;
               end
            end
         end
         StWait: begin
            if (cnt_q == '0) begin
               state_d = StAck;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StAck:   state_d = StTurn;
         StTurn:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs; read data is gated straight from the memory output register.
   always_comb begin
      data_m_ack      = 1'b0;
      data_m_data_out = '0;
      if (state_q == StAck) begin
         data_m_ack = 1'b1;
         if (!wr_q) begin
            data_m_data_out = rdata_q & lane_mask;
         end
      end
   end

`ifdef BOOT_MEM_WRITE_EN
   (* ram_init_file = init_file *) logic [15:0] mem_q [depth];

   logic [15:0] wdata_q, wdata_d;
   logic        locked_q, locked_d;
   logic        wp_q, wp_d;
   logic        mem_we;

   assign wdata_d = accept ? data_m_data_in : wdata_q;

   // The lock checked here is the registered one, so a lock pulse coinciding with this
   // write's ack lands afterwards and does not block it. Reset abandons the write.
   assign mem_we = (state_q == StAck) && wr_q && !locked_q && !reset;

   always_comb begin
      locked_d = locked_q | lock;
      wp_d     = wp_q | ((state_q == StAck) && wr_q && locked_q);
   end

   assign locked       = locked_q;
   assign wp_violation = wp_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wdata_q  <= '0;
         locked_q <= 1'b0;
         wp_q     <= 1'b0;
      end else begin
         wdata_q  <= wdata_d;
         locked_q <= locked_d;
         wp_q     <= wp_d;
      end
   end

   // Memory array: no reset, so contents survive a bus reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         if (bsel_q[0]) begin
            mem_q[addr_q][7:0] <= wdata_q[7:0];
         end
         if (bsel_q[1]) begin
            mem_q[addr_q][15:8] <= wdata_q[15:8];
         end
      end
      rdata_q <= mem_q[addr_d];
   end
`else
   // Read-only: contents come from the image; the zero value only covers an absent image.
   (* ram_init_file = init_file *) logic [15:0] mem_q [depth] = '{default: 16'h0000};

   logic unused_wr;

   assign unused_wr    = ^{lock, data_m_data_in};
   assign locked       = 1'b1;
   assign wp_violation = 1'b0;

   always_ff @(posedge clk) begin
      rdata_q <= mem_q[addr_d];
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         addr_q  <= '0;
         bsel_q  <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         bsel_q  <= bsel_d;
         wr_q    <= wr_d;
      end
   end

endmodule
